pc_lr_sequencer: RTL and testbench
==================================

Name: pc_lr_sequencer

Overview:
- Control-side partner of the Pc/Lr datapath slice.
- Accepts one program-flow command at a time from the instruction decoder over a valid/ready handshake.
- Sequences the datapath strobes for each command: PcEn, PcWe, PcSel, PcIncCin, LrEn, LrSel, LrWe.
- Waits on a bus acknowledge wherever another agent drives or samples SysBus, and flags a bus timeout.

Parameters:
TIMEOUT, 15, maximum wait cycles for BusAck before abort (1..255)
CW, 8, width of the internal wait counter; must hold TIMEOUT

Ports:
Clock  input  1  system clock, all state changes on rising edge
Reset  input  1  synchronous, active-high reset
OpValid  input  1  decoder presents a command
Op  input  3  command: 0 INC, 1 JUMP, 2 CALL, 3 RET, 4 STOREPC, 5 LOADLR, 6/7 illegal
OpReady  output  1  sequencer can accept a command
BusAck  input  1  external agent has driven/sampled SysBus this cycle
PcEn  output  1  Pc drives SysBus
PcWe  output  1  Pc register write enable
PcSel  output  1  Pc source select: 0 incrementer, 1 SysBus
PcIncCin  output  1  incrementer carry-in (1 = PC+1)
LrEn  output  1  Lr drives SysBus
LrSel  output  1  Lr source select: 0 SysBus, 1 Pc
LrWe  output  1  Lr register write enable
Done  output  1  one-cycle pulse in the cycle a command completes
Error  output  1  sticky: bus timeout or illegal op

Behaviour:
- Reset:
  - Sampled at the rising edge; has priority over every other input.
  - Forces state IDLE, wait counter 0, Error 0.
  - All strobes and Done are 0 in the cycle after the Reset edge.
  - Reset mid-command abandons the command with no strobe cycle; datapath register contents are untouched.
- Outputs:
  - Moore decode of state; PcWe/LrWe in wait states are additionally gated by BusAck.
  - No output is ever X after reset.
- OpReady = 1 only in IDLE.
- Command accept:
  - A command is taken on an edge where OpValid & OpReady.
  - Op is captured on that edge; later Op changes are ignored.
- States and transitions:
  - IDLE: all strobes 0. Accept INC->INC, JUMP->LDPC, CALL->SAVE, RET->RET, STOREPC->STPC, LOADLR->LDLR, illegal->IDLE with Error set.
  - INC: PcSel=0, PcIncCin=1, PcWe=1, Done=1 -> IDLE. Latency 1 cycle; throughput 1 op per 2 cycles.
  - SAVE: LrSel=1, LrWe=1 (Lr<=Pc) -> LDPC.
  - LDPC: PcSel=1. PcWe=BusAck; Done=BusAck; BusAck -> IDLE.
  - RET: LrEn=1, PcSel=1, PcWe=1, Done=1 -> IDLE (Pc<=Lr via SysBus).
  - STPC: PcEn=1 for every cycle in state. Done=BusAck; BusAck -> IDLE.
  - LDLR: LrSel=0. LrWe=BusAck; Done=BusAck; BusAck -> IDLE.
- Bus exclusivity: PcEn and LrEn are never 1 together, and neither is 1 in LDPC/LDLR, where an external agent owns SysBus.
- Wait counter (LDPC/STPC/LDLR):
  - Cleared on state entry; increments each cycle BusAck=0.
  - Reaching TIMEOUT with BusAck=0: Error<=1, state -> IDLE, Done stays 0, no write strobe that cycle.
  - BusAck on the same cycle the count reaches TIMEOUT counts as success; Error is not set.
  - Counter saturates and never wraps.
- Error:
  - Cleared only by Reset.
  - Does not block further commands.
- OpValid while busy: ignored. The decoder must hold it until OpReady.

Test Plan:
- Reset held 2 cycles mid-STPC wait -> next cycle IDLE, OpReady=1, all strobes 0, Error=0.
- INC accepted at edge t -> cycle t+1: PcWe=PcIncCin=1, PcSel=0, Done=1; cycle t+2: OpReady=1. Four back-to-back INCs -> Done at t+1, t+3, t+5, t+7.
- CALL, BusAck low 3 cycles then high -> LrSel=LrWe=1 for 1 cycle; then PcSel=1 for 4 cycles with PcWe=Done=1 only in the 4th; PcEn=LrEn=0 throughout.
- RET -> single cycle LrEn=PcSel=PcWe=Done=1, PcEn=0. LOADLR with BusAck immediately -> LrSel=0, LrWe=Done=1 in the first state cycle.
- STOREPC, BusAck never asserted, TIMEOUT=15 -> PcEn=1 for the state cycles, Error rises at the timeout, Done never pulses, returns to IDLE; next INC still executes.
- Op=6 accepted -> Error=1, no strobe, OpReady stays 1. BusAck arriving exactly on the timeout cycle -> Done=1, Error stays 0.

Source files
------------

// File: rtl/pc_lr_sequencer_if.sv
// Decoder/bus-side handshake and datapath strobe bundle
// for the Pc/Lr sequencer.
interface pc_lr_sequencer_if;
  logic       OpValid;
  logic [2:0] Op;
  logic       OpReady;
  logic       BusAck;
  logic       PcEn;
  logic       PcWe;
  logic       PcSel;
  logic       PcIncCin;
  logic       LrEn;
  logic       LrSel;
  logic       LrWe;
  logic       Done;
  logic       Error;

  modport master (
    output OpValid,
    output Op,
    output BusAck,
    input  OpReady,
    input  PcEn,
    input  PcWe,
    input  PcSel,
    input  PcIncCin,
    input  LrEn,
    input  LrSel,
    input  LrWe,
    input  Done,
    input  Error
  );

  modport slave (
    input  OpValid,
    input  Op,
    input  BusAck,
    output OpReady,
    output PcEn,
    output PcWe,
    output PcSel,
    output PcIncCin,
    output LrEn,
    output LrSel,
    output LrWe,
    output Done,
    output Error
  );
endinterface

// File: rtl/pc_lr_sequencer.sv
// Program-flow command sequencer driving the Pc/Lr
// datapath strobes, with bus-ack waits and timeout.
module pc_lr_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input logic               Clock,
  input logic               Reset,
  pc_lr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    INC,
    SAVE,
    LDPC,
    RET,
    STPC,
    LDLR
  } state_t;

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] waitCntNext;
  logic [CW-1:0] cntInc;
  logic          errorQ;
  logic          errorNext;
  logic          expire;

  logic opReady;
  logic pcEn;
  logic pcWe;
  logic pcSel;
  logic pcIncCin;
  logic lrEn;
  logic lrSel;
  logic lrWe;
  logic done;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      errorQ  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      errorQ  <= errorNext;
    end
  end

  // waitCnt holds the number of ack-less cycles already spent,
  // so the last permitted wait cycle sees waitCnt == TIMEOUT-1
  assign cntInc = (waitCnt >= SAT) ? waitCnt : waitCnt + 1'b1;
  assign expire = !bus.BusAck && (waitCnt >= LIMIT);

  always_comb begin
    stateNext   = state;
    waitCntNext = '0;
    errorNext   = errorQ;
    opReady     = 1'b0;
    pcEn        = 1'b0;
    pcWe        = 1'b0;
    pcSel       = 1'b0;
    pcIncCin    = 1'b0;
    lrEn        = 1'b0;
    lrSel       = 1'b0;
    lrWe        = 1'b0;
    done        = 1'b0;

    unique case (state)
      IDLE: begin
        opReady = 1'b1;
        if (bus.OpValid) begin
          case (bus.Op)
            3'd0:    stateNext = INC;
            3'd1:    stateNext = LDPC;
            3'd2:    stateNext = SAVE;
            3'd3:    stateNext = RET;
            3'd4:    stateNext = STPC;
            3'd5:    stateNext = LDLR;
            default: errorNext = 1'b1;
          endcase
        end
      end
      INC: begin
        pcIncCin  = 1'b1;
        pcWe      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      SAVE: begin
        lrSel     = 1'b1;
        lrWe      = 1'b1;
        stateNext = LDPC;
      end
      RET: begin
        lrEn      = 1'b1;
        pcSel     = 1'b1;
        pcWe      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      LDPC: begin
        pcSel = 1'b1;
        if (bus.BusAck) begin
          pcWe      = 1'b1;
          done      = 1'b1;
          stateNext = IDLE;
        end else if (expire) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          waitCntNext = cntInc;
        end
      end
      STPC: begin
        pcEn = 1'b1;
        if (bus.BusAck) begin
          done      = 1'b1;
          stateNext = IDLE;
        end else if (expire) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          waitCntNext = cntInc;
        end
      end
      LDLR: begin
        if (bus.BusAck) begin
          lrWe      = 1'b1;
          done      = 1'b1;
          stateNext = IDLE;
        end else if (expire) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          waitCntNext = cntInc;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.OpReady  = opReady;
  assign bus.PcEn     = pcEn;
  assign bus.PcWe     = pcWe;
  assign bus.PcSel    = pcSel;
  assign bus.PcIncCin = pcIncCin;
  assign bus.LrEn     = lrEn;
  assign bus.LrSel    = lrSel;
  assign bus.LrWe     = lrWe;
  assign bus.Done     = done;
  assign bus.Error    = errorQ;

endmodule

// File: tb/tb_pc_lr_sequencer.sv
// Directed plus randomized check of pc_lr_sequencer against
// a per-command expected-trace model.
module tb_pc_lr_sequencer;

  localparam int TO = 15;

  localparam logic [9:0] PCEN  = 10'h200;
  localparam logic [9:0] PCWE  = 10'h100;
  localparam logic [9:0] PCSEL = 10'h080;
  localparam logic [9:0] CIN   = 10'h040;
  localparam logic [9:0] LREN  = 10'h020;
  localparam logic [9:0] LRSEL = 10'h010;
  localparam logic [9:0] LRWE  = 10'h008;
  localparam logic [9:0] DONE  = 10'h004;
  localparam logic [9:0] RDY   = 10'h002;
  localparam logic [9:0] ERR   = 10'h001;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic errM  = 1'b0;

  pc_lr_sequencer_if bus ();

  pc_lr_sequencer #(
    .TIMEOUT (TO),
    .CW      (8)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  function automatic logic [9:0] obs();
    return {bus.PcEn, bus.PcWe, bus.PcSel, bus.PcIncCin,
            bus.LrEn, bus.LrSel, bus.LrWe, bus.Done,
            bus.OpReady, bus.Error};
  endfunction

  // One clock cycle: drive inputs after the edge, check late.
  task automatic step(input logic v, input logic [2:0] o,
                      input logic a, input logic [9:0] e,
                      input string tag);
    logic [9:0] exp;
    @(posedge Clock);
    #1;
    bus.OpValid = v;
    bus.Op      = o;
    bus.BusAck  = a;
    #3;
    exp = e | (errM ? ERR : 10'h000);
    total++;
    assert (obs() === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, obs(), exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // a = wait-phase cycle index where BusAck arrives; a >= TO
  // means it never arrives and the command must time out.
  task automatic runCmd(input logic [2:0] op, input int a,
                        input string tag);
    logic [9:0] q[$];
    int         pre;
    int         n;
    logic       ok;
    logic       isWait;
    logic [9:0] base;
    logic [9:0] fin;
    logic       ack;

    pre    = 0;
    isWait = 1'b0;
    base   = '0;
    fin    = '0;
    ok     = (a < TO);
    n      = ok ? a + 1 : TO;
    case (op)
      3'd0: q.push_back(PCWE | CIN | DONE);
      3'd3: q.push_back(LREN | PCSEL | PCWE | DONE);
      3'd1: begin
        isWait = 1'b1; base = PCSEL; fin = PCWE | DONE;
      end
      3'd2: begin
        q.push_back(LRSEL | LRWE);
        pre = 1;
        isWait = 1'b1; base = PCSEL; fin = PCWE | DONE;
      end
      3'd4: begin
        isWait = 1'b1; base = PCEN; fin = DONE;
      end
      3'd5: begin
        isWait = 1'b1; base = '0; fin = LRWE | DONE;
      end
      default: ;
    endcase
    if (isWait) begin
      for (int i = 0; i < n; i++)
        q.push_back(base | ((ok && i == n - 1) ? fin : '0));
    end

    step(1'b1, op, rbit(), RDY, {tag, "/accept"});
    if (op > 3'd5) errM = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      if (isWait && k >= pre)
        ack = ((k - pre) == a);
      else
        ack = rbit();
      step(rbit(), 3'($urandom), ack, q[k],
           $sformatf("%s/c%0d", tag, k));
    end
    if (isWait && !ok) errM = 1'b1;
  endtask

  initial begin
    bus.OpValid = 1'b0;
    bus.Op      = 3'd0;
    bus.BusAck  = 1'b0;

    step(1'b0, 3'd0, 1'b0, RDY, "reset");
    Reset = 1'b0;
    step(1'b0, 3'd0, 1'b0, RDY, "idle");

    // four back-to-back INCs: Done every other cycle
    for (int i = 0; i < 4; i++) runCmd(3'd0, 0, "inc");
    runCmd(3'd2, 3, "call");
    runCmd(3'd3, 0, "ret");
    runCmd(3'd5, 0, "loadlr");
    runCmd(3'd4, TO - 1, "stpc_edge");
    runCmd(3'd1, TO - 1, "jump_edge");
    runCmd(3'd4, TO + 5, "stpc_to");
    runCmd(3'd0, 0, "inc_after_err");
    runCmd(3'd6, 0, "illegal6");
    runCmd(3'd7, 0, "illegal7");
    runCmd(3'd1, 2, "jump_after_err");

    // reset held two cycles in the middle of a STPC wait
    step(1'b1, 3'd4, 1'b0, RDY, "rst_stpc/accept");
    step(1'b0, 3'd0, 1'b0, PCEN, "rst_stpc/w0");
    step(1'b0, 3'd0, 1'b0, PCEN, "rst_stpc/w1");
    Reset = 1'b1;
    errM  = 1'b0;
    step(1'b0, 3'd0, 1'b0, RDY, "rst_stpc/r1");
    step(1'b1, 3'd1, 1'b0, RDY, "rst_stpc/r2");
    Reset = 1'b0;
    bus.OpValid = 1'b0;
    step(1'b0, 3'd0, 1'b1, RDY, "rst_stpc/post");

    for (int i = 0; i < 60; i++)
      runCmd(3'($urandom_range(0, 7)),
             int'($urandom_range(0, TO + 2)),
             $sformatf("rnd%0d", i));

    step(1'b0, 3'd0, 1'b0, RDY, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
